// File: rtl/hue_bbox_tracker.sv
// Per-frame hue-window classifier: bounding box and count of matching pixels, published once per frame.
// Optional HUE_BBOX_CENTROID_EN adds per-frame coordinate sums for centroid computation on the HPS side.
module hue_bbox_tracker #(
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int HUE_WIDTH   = 9,
    parameter int COUNT_WIDTH = 20,
    parameter int MIN_PIXELS  = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iFVAL,
    input  logic                   iDVAL,
    input  logic [X_WIDTH-1:0]     iX,
    input  logic [Y_WIDTH-1:0]     iY,
    input  logic [HUE_WIDTH-1:0]   iHUE,
    input  logic [HUE_WIDTH-1:0]   iHUE_LO,
    input  logic [HUE_WIDTH-1:0]   iHUE_HI,
    output logic [X_WIDTH-1:0]     oX_MIN,
    output logic [X_WIDTH-1:0]     oX_MAX,
    output logic [Y_WIDTH-1:0]     oY_MIN,
    output logic [Y_WIDTH-1:0]     oY_MAX,
    output logic [COUNT_WIDTH-1:0] oCOUNT,
    output logic                   oFOUND,
    output logic                   oVALID,
    output logic                   oBUSY
`ifdef HUE_BBOX_CENTROID_EN
    ,
    output logic [X_WIDTH+COUNT_WIDTH-1:0] oX_SUM,
    output logic [Y_WIDTH+COUNT_WIDTH-1:0] oY_SUM
`endif
);

    typedef enum logic [2:0] {WAIT_LOW, ARMED, ACCUM, FLUSH, PUBLISH} state_t;

    state_t                 state_q, state_d;
    logic                   fval_prev_q, fval_prev_d;
    logic [HUE_WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
    logic                   match_q, match_d;
    logic [X_WIDTH-1:0]     mx_q, mx_d;
    logic [Y_WIDTH-1:0]     my_q, my_d;
    logic [X_WIDTH-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_WIDTH-1:0]     ymin_q, ymin_d, ymax_q, ymax_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [X_WIDTH-1:0]     ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [Y_WIDTH-1:0]     oy_min_q, oy_min_d, oy_max_q, oy_max_d;
    logic [COUNT_WIDTH-1:0] ocount_q, ocount_d;
    logic                   ofound_q, ofound_d, ovalid_q, ovalid_d, obusy_q, obusy_d;
    logic                   in_win;
`ifdef HUE_BBOX_CENTROID_EN
    logic [X_WIDTH+COUNT_WIDTH-1:0] xsum_q, xsum_d, ox_sum_q, ox_sum_d;
    logic [Y_WIDTH+COUNT_WIDTH-1:0] ysum_q, ysum_d, oy_sum_q, oy_sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        fval_prev_d = iFVAL;
        lo_d        = lo_q;
        hi_d        = hi_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        count_d     = count_q;
        ox_min_d    = ox_min_q;
        ox_max_d    = ox_max_q;
        oy_min_d    = oy_min_q;
        oy_max_d    = oy_max_q;
        ocount_d    = ocount_q;
        ofound_d    = ofound_q;
        ovalid_d    = 1'b0;
`ifdef HUE_BBOX_CENTROID_EN
        xsum_d      = xsum_q;
        ysum_d      = ysum_q;
        ox_sum_d    = ox_sum_q;
        oy_sum_d    = oy_sum_q;
`endif

        // lo > hi means the window wraps through 0 (red)
        if (lo_q <= hi_q) in_win = (iHUE >= lo_q) && (iHUE <= hi_q);
        else              in_win = (iHUE >= lo_q) || (iHUE <= hi_q);
        match_d = iDVAL && iFVAL && (state_q == ACCUM) && in_win;
        mx_d    = iX;
        my_d    = iY;

        if (match_q && (state_q == ACCUM || state_q == FLUSH)) begin
            if (mx_q < xmin_q) xmin_d = mx_q;
            if (mx_q > xmax_q) xmax_d = mx_q;
            if (my_q < ymin_q) ymin_d = my_q;
            if (my_q > ymax_q) ymax_d = my_q;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
`ifdef HUE_BBOX_CENTROID_EN
                xsum_d  = xsum_q + (X_WIDTH+COUNT_WIDTH)'(mx_q);
                ysum_d  = ysum_q + (Y_WIDTH+COUNT_WIDTH)'(my_q);
`endif
            end
        end

        case (state_q)
            WAIT_LOW: if (!iFVAL) state_d = ARMED;
            ARMED: begin
                // fval_prev_q stops a frame that rose during FLUSH/PUBLISH from being picked up late
                if (!fval_prev_q && iFVAL) begin
                    state_d = ACCUM;
                    lo_d    = iHUE_LO;
                    hi_d    = iHUE_HI;
                    xmin_d  = '1;
                    xmax_d  = '0;
                    ymin_d  = '1;
                    ymax_d  = '0;
                    count_d = '0;
`ifdef HUE_BBOX_CENTROID_EN
                    xsum_d  = '0;
                    ysum_d  = '0;
`endif
                end
            end
            ACCUM: if (!iFVAL) state_d = FLUSH;
            FLUSH: state_d = PUBLISH;
            PUBLISH: begin
                state_d  = ARMED;
                ovalid_d = 1'b1;
                ocount_d = count_q;
                ofound_d = (count_q >= COUNT_WIDTH'(MIN_PIXELS));
                ox_min_d = (count_q == '0) ? '0 : xmin_q;
                ox_max_d = xmax_q;
                oy_min_d = (count_q == '0) ? '0 : ymin_q;
                oy_max_d = ymax_q;
`ifdef HUE_BBOX_CENTROID_EN
                ox_sum_d = xsum_q;
                oy_sum_d = ysum_q;
`endif
            end
            default: state_d = WAIT_LOW;
        endcase

        obusy_d = (state_d == ACCUM) || (state_d == FLUSH);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= WAIT_LOW;
            fval_prev_q <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            match_q     <= 1'b0;
            mx_q        <= '0;
            my_q        <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            count_q     <= '0;
            ox_min_q    <= '0;
            ox_max_q    <= '0;
            oy_min_q    <= '0;
            oy_max_q    <= '0;
            ocount_q    <= '0;
            ofound_q    <= 1'b0;
            ovalid_q    <= 1'b0;
            obusy_q     <= 1'b0;
`ifdef HUE_BBOX_CENTROID_EN
            xsum_q      <= '0;
            ysum_q      <= '0;
            ox_sum_q    <= '0;
            oy_sum_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fval_prev_q <= fval_prev_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            match_q     <= match_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            count_q     <= count_d;
            ox_min_q    <= ox_min_d;
            ox_max_q    <= ox_max_d;
            oy_min_q    <= oy_min_d;
            oy_max_q    <= oy_max_d;
            ocount_q    <= ocount_d;
            ofound_q    <= ofound_d;
            ovalid_q    <= ovalid_d;
            obusy_q     <= obusy_d;
`ifdef HUE_BBOX_CENTROID_EN
            xsum_q      <= xsum_d;
            ysum_q      <= ysum_d;
            ox_sum_q    <= ox_sum_d;
            oy_sum_q    <= oy_sum_d;
`endif
        end
    end

    assign oX_MIN = ox_min_q;
    assign oX_MAX = ox_max_q;
    assign oY_MIN = oy_min_q;
    assign oY_MAX = oy_max_q;
    assign oCOUNT = ocount_q;
    assign oFOUND = ofound_q;
    assign oVALID = ovalid_q;
    assign oBUSY  = obusy_q;
`ifdef HUE_BBOX_CENTROID_EN
    assign oX_SUM = ox_sum_q;
    assign oY_SUM = oy_sum_q;
`endif

endmodule

// File: tb/tb_hue_bbox_tracker.sv
// Self-checking bench for hue_bbox_tracker: directed frames plus random frames against a pixel-list model.
module tb_hue_bbox_tracker;
    localparam int XW = 12, YW = 12, HW = 9, CW = 20, MINP = 16;

    logic iCLK = 1'b0;
    logic iRST, iFVAL, iDVAL;
    logic [XW-1:0] iX;
    logic [YW-1:0] iY;
    logic [HW-1:0] iHUE, iHUE_LO, iHUE_HI;
    logic [XW-1:0] oX_MIN, oX_MAX;
    logic [YW-1:0] oY_MIN, oY_MAX;
    logic [CW-1:0] oCOUNT;
    logic oFOUND, oVALID, oBUSY;
`ifdef HUE_BBOX_CENTROID_EN
    logic [XW+CW-1:0] oX_SUM;
    logic [YW+CW-1:0] oY_SUM;
`endif

    hue_bbox_tracker #(.X_WIDTH(XW), .Y_WIDTH(YW), .HUE_WIDTH(HW), .COUNT_WIDTH(CW), .MIN_PIXELS(MINP)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL), .iX(iX), .iY(iY), .iHUE(iHUE),
        .iHUE_LO(iHUE_LO), .iHUE_HI(iHUE_HI), .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN),
        .oY_MAX(oY_MAX), .oCOUNT(oCOUNT), .oFOUND(oFOUND), .oVALID(oVALID), .oBUSY(oBUSY)
`ifdef HUE_BBOX_CENTROID_EN
        , .oX_SUM(oX_SUM), .oY_SUM(oY_SUM)
`endif
    );

    always #5 iCLK = ~iCLK;

    int checks = 0, errors = 0;
    int qx[$], qy[$], qh[$];
    int e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;
    logic e_found;
    int v_first, v_count;
    logic busy_mid;
    logic [XW-1:0] s_xmin, s_xmax;
    logic [YW-1:0] s_ymin, s_ymax;
    logic [CW-1:0] s_cnt;
    logic s_found;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic bit in_window(int h, int lo, int hi);
        if (lo <= hi) return (h >= lo) && (h <= hi);
        return (h >= lo) || (h <= hi);
    endfunction

    // Reference: scan the frame's pixel list and reduce matching ones to bbox/count
    task automatic model(input int lo, input int hi);
        e_cnt = 0; e_xmin = 1 << 30; e_xmax = -1; e_ymin = 1 << 30; e_ymax = -1;
        foreach (qx[i]) if (in_window(qh[i], lo, hi)) begin
            e_cnt++;
            if (qx[i] < e_xmin) e_xmin = qx[i];
            if (qx[i] > e_xmax) e_xmax = qx[i];
            if (qy[i] < e_ymin) e_ymin = qy[i];
            if (qy[i] > e_ymax) e_ymax = qy[i];
        end
        if (e_cnt == 0) begin e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; end
        e_found = (e_cnt >= MINP);
    endtask

    task automatic add_px(input int x, input int y, input int h);
        qx.push_back(x); qy.push_back(y); qh.push_back(h);
    endtask

    // Drives one frame from the pixel queues, then watches 6 cycles after iFVAL falls
    task automatic drive_frame(input int lo, input int hi, input int lo_mid, input bit gaps);
        iHUE_LO = HW'(lo); iHUE_HI = HW'(hi);
        iFVAL = 1'b1; iDVAL = 1'b0;
        tick();
        busy_mid = oBUSY;
        foreach (qx[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin iDVAL = 1'b0; tick(); end
            iDVAL = 1'b1; iX = XW'(qx[i]); iY = YW'(qy[i]); iHUE = HW'(qh[i]);
            if (i == qx.size() / 2 && lo_mid >= 0) iHUE_LO = HW'(lo_mid);
            tick();
        end
        iDVAL = 1'b0; iFVAL = 1'b0;
        v_first = -1; v_count = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (oVALID === 1'b1) begin
                v_count++;
                if (v_first < 0) begin
                    v_first = t;
                    s_xmin = oX_MIN; s_xmax = oX_MAX; s_ymin = oY_MIN; s_ymax = oY_MAX;
                    s_cnt = oCOUNT; s_found = oFOUND;
                end
            end
        end
    endtask

    task automatic test_reset();
        int busy_seen, valid_seen;
        iRST = 1'b1; iFVAL = 1'b0; iDVAL = 1'b0; iX = '0; iY = '0; iHUE = '0; iHUE_LO = '0; iHUE_HI = 9'd359;
        tick(); tick();
        checks++;
        if ({oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCOUNT, oFOUND, oVALID, oBUSY} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got bbox %0d/%0d/%0d/%0d cnt %0d found %b valid %b busy %b, want all 0",
                     oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCOUNT, oFOUND, oVALID, oBUSY);
        end
        // Leave reset mid-frame: that partial frame must never be published
        iFVAL = 1'b1; tick();
        iRST = 1'b0;
        busy_seen = 0; valid_seen = 0;
        for (int i = 0; i < 100; i++) begin
            iDVAL = 1'b1; iX = XW'(i); iY = YW'(i); iHUE = HW'(10);
            tick();
            busy_seen += oBUSY; valid_seen += oVALID;
        end
        iDVAL = 1'b0; iFVAL = 1'b0;
        for (int t = 0; t < 8; t++) begin tick(); busy_seen += oBUSY; valid_seen += oVALID; end
        checks++;
        if (valid_seen != 0 || busy_seen != 0 || oCOUNT !== '0) begin
            errors++;
            $display("FAIL reset_partial_frame: valid %0d busy %0d cnt %0d, want 0 0 0", valid_seen, busy_seen, oCOUNT);
        end
    endtask

    task automatic test_basic();
        qx.delete(); qy.delete(); qh.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                add_px(x, y, ((x == 2 && y == 1) || (x == 5 && y == 3)) ? 10 : 200);
        drive_frame(0, 20, -1, 1'b1);
        checks++;
        if (v_first != 3 || v_count != 1 || busy_mid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: valid tick %0d pulses %0d busy %b, want tick 3 pulses 1 busy 1", v_first, v_count, busy_mid);
        end
        checks++;
        if ({s_xmin, s_xmax, s_ymin, s_ymax} !== {12'd2, 12'd5, 12'd1, 12'd3} || s_cnt !== 20'd2 || s_found !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d %0d %0d %0d cnt %0d found %b, want 2 5 1 3 cnt 2 found 0",
                     s_xmin, s_xmax, s_ymin, s_ymax, s_cnt, s_found);
        end
        checks++;
        if (oCOUNT !== 20'd2 || oX_MAX !== 12'd5 || oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: cnt %0d xmax %0d busy %b, want 2 5 0", oCOUNT, oX_MAX, oBUSY);
        end
    endtask

    task automatic test_wrap();
        qx.delete(); qy.delete(); qh.delete();
        add_px(10, 6, 350); add_px(11, 6, 5); add_px(12, 6, 200); add_px(13, 6, 15); add_px(14, 6, 339);
        drive_frame(340, 15, -1, 1'b0);
        checks++;
        if (v_first != 3 || s_cnt !== 20'd3 || {s_xmin, s_xmax, s_ymin, s_ymax} !== {12'd10, 12'd13, 12'd6, 12'd6}) begin
            errors++;
            $display("FAIL wrap_window: tick %0d cnt %0d bbox %0d %0d %0d %0d, want tick 3 cnt 3 bbox 10 13 6 6",
                     v_first, s_cnt, s_xmin, s_xmax, s_ymin, s_ymax);
        end
    endtask

    task automatic test_found();
        qx.delete(); qy.delete(); qh.delete();
        for (int i = 0; i < 20; i++) add_px(7, 7, 5);
        drive_frame(0, 20, -1, 1'b1);
        checks++;
        if (v_first != 3 || s_cnt !== 20'd20 || s_found !== 1'b1 || {s_xmin, s_xmax, s_ymin, s_ymax} !== {12'd7, 12'd7, 12'd7, 12'd7}) begin
            errors++;
            $display("FAIL found_threshold: tick %0d cnt %0d found %b bbox %0d %0d %0d %0d, want 3 20 1 7 7 7 7",
                     v_first, s_cnt, s_found, s_xmin, s_xmax, s_ymin, s_ymax);
        end
    endtask

    task automatic test_no_match();
        qx.delete(); qy.delete(); qh.delete();
        for (int i = 0; i < 8; i++) add_px(i + 3, 9, 200);
        drive_frame(0, 20, -1, 1'b0);
        checks++;
        if (v_first != 3 || v_count != 1 || {s_xmin, s_xmax, s_ymin, s_ymax, s_cnt, s_found} !== '0) begin
            errors++;
            $display("FAIL no_match: tick %0d pulses %0d bbox %0d %0d %0d %0d cnt %0d found %b, want tick 3 pulse 1 all 0",
                     v_first, v_count, s_xmin, s_xmax, s_ymin, s_ymax, s_cnt, s_found);
        end
    endtask

    task automatic test_threshold_change();
        qx.delete(); qy.delete(); qh.delete();
        add_px(1, 1, 50); add_px(3, 2, 120); add_px(4, 4, 50); add_px(6, 5, 120);
        drive_frame(0, 150, 100, 1'b0);
        checks++;
        if (s_cnt !== 20'd4 || {s_xmin, s_xmax, s_ymin, s_ymax} !== {12'd1, 12'd6, 12'd1, 12'd5}) begin
            errors++;
            $display("FAIL thresh_current_frame: cnt %0d bbox %0d %0d %0d %0d, want 4 bbox 1 6 1 5", s_cnt, s_xmin, s_xmax, s_ymin, s_ymax);
        end
        drive_frame(100, 150, -1, 1'b0);
        checks++;
        if (s_cnt !== 20'd2 || {s_xmin, s_xmax, s_ymin, s_ymax} !== {12'd3, 12'd6, 12'd2, 12'd5}) begin
            errors++;
            $display("FAIL thresh_next_frame: cnt %0d bbox %0d %0d %0d %0d, want 2 bbox 3 6 2 5", s_cnt, s_xmin, s_xmax, s_ymin, s_ymax);
        end
    endtask

    task automatic test_rst_mid();
        int valid_seen;
        iHUE_LO = '0; iHUE_HI = 9'd359;
        iFVAL = 1'b1; iDVAL = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin iDVAL = 1'b1; iX = XW'(i); iY = YW'(i); iHUE = HW'(30); tick(); end
        checks++;
        if (oBUSY !== 1'b1 || oCOUNT === '0) begin
            errors++;
            $display("FAIL rst_mid_precondition: busy %b cnt %0d, want busy 1 and previous nonzero count", oBUSY, oCOUNT);
        end
        iRST = 1'b1;
        #1;
        checks++;
        if ({oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCOUNT, oFOUND, oVALID, oBUSY} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: bbox %0d %0d %0d %0d cnt %0d found %b valid %b busy %b, want all 0",
                     oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCOUNT, oFOUND, oVALID, oBUSY);
        end
        tick(); tick();
        iRST = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); valid_seen += oVALID; end
        iDVAL = 1'b0; iFVAL = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); valid_seen += oVALID; end
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("FAIL rst_mid_no_valid: saw %0d valid pulses, want 0", valid_seen);
        end
    endtask

    task automatic test_random();
        int lo, hi, n;
        for (int f = 0; f < 8; f++) begin
            qx.delete(); qy.delete(); qh.delete();
            lo = $urandom_range(0, 359); hi = $urandom_range(0, 359); n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) add_px($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 359));
            model(lo, hi);
            drive_frame(lo, hi, -1, 1'b1);
            checks++;
            if (v_first != 3 || v_count != 1 || s_cnt !== CW'(e_cnt) || s_found !== e_found ||
                {s_xmin, s_xmax, s_ymin, s_ymax} !== {XW'(e_xmin), XW'(e_xmax), YW'(e_ymin), YW'(e_ymax)}) begin
                errors++;
                $display("FAIL random_frame%0d: tick %0d cnt %0d found %b bbox %0d %0d %0d %0d, want tick 3 cnt %0d found %b bbox %0d %0d %0d %0d",
                         f, v_first, s_cnt, s_found, s_xmin, s_xmax, s_ymin, s_ymax, e_cnt, e_found, e_xmin, e_xmax, e_ymin, e_ymax);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_found();
        test_no_match();
        test_threshold_change();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
